// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-256 round sequencer.
// The FSM encoding lives here so benches and debug logic can name the states.
package aes_ctrl_pkg;

    localparam int AES_NR    = 14;
    localparam int AES_BLK_W = 128;

    typedef logic [AES_BLK_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/aes256_round_sched.sv
// Sequences one block through the shared combinational AES round datapath:
// initial AddRoundKey on accept, NR rounds at one per clock, then hold the ciphertext.
module aes256_round_sched
    import aes_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = AES_BLK_W,
    parameter int NR         = AES_NR,
    parameter int KIDX_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_loaded,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [KIDX_W-1:0]     key_idx,
    input  logic [DATA_WIDTH-1:0] key_data,
    output logic [DATA_WIDTH-1:0] dp_state,
    output logic [DATA_WIDTH-1:0] dp_key,
    output logic                  dp_last,
    input  logic [DATA_WIDTH-1:0] dp_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic [KIDX_W-1:0]     round,
    output sched_state_e          state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready, and out_data holds until taken.

    localparam logic [KIDX_W-1:0] LAST_ROUND = KIDX_W'(NR);

    if (NR >= (1 << KIDX_W)) begin : g_nr_check
        $error("NR does not fit in KIDX_W bits");
    end

    sched_state_e          fsm;
    logic [KIDX_W-1:0]     round_q;
    logic [DATA_WIDTH-1:0] state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm     <= IDLE;
            round_q <= '0;
            state_q <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_q <= in_data ^ key_data;
                        round_q <= KIDX_W'(1);
                        fsm     <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= dp_result;
                    // round stays at NR through DONE so the debug view shows the final round
                    if (round_q == LAST_ROUND) begin
                        fsm <= DONE;
                    end else begin
                        round_q <= round_q + KIDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        round_q <= '0;
                        fsm     <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (fsm == IDLE) && key_loaded;
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);
    assign key_idx   = (fsm == ROUND) ? round_q : '0;
    assign dp_last   = (fsm == ROUND) && (round_q == LAST_ROUND);
    // dp_state follows the register in every state so the datapath is quiet while idle
    assign dp_state  = state_q;
    assign dp_key    = key_data;
    assign out_data  = state_q;
    assign round     = round_q;
    assign state_dbg = fsm;

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

    a_hs_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));

    a_round_range: assert property (@(posedge clk) disable iff (!rst_n)
        round_q <= LAST_ROUND);

endmodule

// File: tb/tb_aes256_round_sched.sv
// Bench for aes256_round_sched: real AES round datapath and key-schedule store
// around the sequencer, directed vectors plus multi-cycle corner sequences.
module tb_aes256_round_sched;
    import aes_ctrl_pkg::*;

    localparam logic [127:0] C3_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n, key_loaded, in_valid, out_ready;
    logic         in_ready, dp_last, out_valid, busy;
    logic [127:0] in_data, key_data, dp_state, dp_key, dp_result, out_data;
    logic [3:0]   key_idx, round;
    sched_state_e state_dbg;

    logic [127:0] rk [15];
    logic [31:0]  w [60];
    logic [127:0] exp_q[$];

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
        string        name;
    } vec_t;
    vec_t vt [3];

    int total, bad, cyc, out_cnt, lat_last, last_acc, n_exp;
    logic ov_prev, or_prev;
    logic [127:0] held;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes256_round_sched dut (
        .clk(clk), .rst_n(rst_n), .key_loaded(key_loaded),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_idx(key_idx), .key_data(key_data),
        .dp_state(dp_state), .dp_key(dp_key), .dp_last(dp_last), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .round(round), .state_dbg(state_dbg)
    );

    // ---------------- AES reference functions ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t = x;
        logic [7:0] r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = b[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
        logic [127:0] s = pt ^ rk[0];
        for (int r = 1; r <= 14; r++) s = aes_round(s, rk[r], r == 14);
        return s;
    endfunction

    // datapath and key store seen by the DUT
    assign key_data = (key_idx <= 4'd14) ? rk[key_idx] : '0;
    always_comb dp_result = aes_round(dp_state, dp_key, dp_last);

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic wait_accept(output int acc_cyc);
        acc_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc_cyc = cyc;
                break;
            end
        end
        check("accept_timeout", 128'(acc_cyc >= 0), 128'(1));
    endtask

    task automatic wait_out(input int target);
        int i = 0;
        while (out_cnt < target && i < 80) begin
            @(negedge clk);
            i++;
        end
        check("output_timeout", 128'(out_cnt >= target), 128'(1));
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] ct, input string name);
        int acc;
        int n0 = out_cnt;
        exp_q.push_back(ct);
        n_exp++;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = pt;
        wait_accept(acc);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        wait_out(n0 + 1);
        check({"latency_", name}, 128'(lat_last), 128'(15));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        ov_prev = 1'b0;
        or_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("hs_exclusive", 128'(in_ready && out_valid), 128'(0));
                if (ov_prev && !or_prev) begin
                    check("hold_valid", 128'(out_valid), 128'(1));
                    check("hold_data", out_data, held);
                end
                if (busy && !out_valid) begin
                    check("key_idx_round", 128'(key_idx), 128'(cyc - last_acc));
                    check("round_round", 128'(round), 128'(cyc - last_acc));
                    check("key_loaded_in_round", 128'(key_loaded), 128'(1));
                end
                if (!busy) begin
                    check("key_idx_idle", 128'(key_idx), 128'(0));
                    check("round_idle", 128'(round), 128'(0));
                end
                if (out_valid) check("round_done", 128'(round), 128'(14));
                check("dp_last", 128'(dp_last),
                      128'(busy && !out_valid && (cyc - last_acc) == 14));
                if (out_valid && !ov_prev) lat_last = cyc - last_acc;
                if (out_valid && out_ready) begin
                    out_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got %h expected none", out_data);
                    end else begin
                        check("ciphertext", out_data, exp_q.pop_front());
                    end
                end
                if (in_valid && in_ready) last_acc = cyc;
                ov_prev = out_valid;
                or_prev = out_ready;
                held    = out_data;
            end else begin
                ov_prev = 1'b0;
                or_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [255:0] key;
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] od;
        int a1, a2, h, n0;

        rst_n = 1'b0; key_loaded = 1'b1; in_valid = 1'b1; in_data = '1; out_ready = 1'b0;

        for (int i = 0; i < 32; i++) key[255-8*i -: 8] = 8'(i);
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (i % 8 == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        vt[0].pt = C3_PT;  vt[0].ct = C3_CT;               vt[0].name = "c3";
        vt[1].pt = '0;     vt[1].ct = ref_encrypt('0);     vt[1].name = "zero";
        vt[2].pt = '1;     vt[2].ct = ref_encrypt('1);     vt[2].name = "ones";

        // reset state, with key_loaded and in_valid high to show in_ready stays low
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_dp_last", 128'(dp_last), 128'(0));
        check("rst_key_idx", 128'(key_idx), 128'(0));
        check("rst_round", 128'(round), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_state", 128'(state_dbg), 128'(IDLE));
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 128'(in_ready), 128'(1));

        for (int i = 0; i < 3; i++) run_block(vt[i].pt, vt[i].ct, vt[i].name);

        // backpressure: ciphertext held for 20 cycles, pending block not taken
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_q.push_back(C3_CT); n_exp++;
        n0 = out_cnt;
        in_valid = 1'b1; in_data = C3_PT;
        wait_accept(a1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        check("bp_valid_seen", 128'(out_valid), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = vt[1].pt;
        exp_q.push_back(vt[1].ct); n_exp++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) check("bp_latency", 128'(lat_last), 128'(15));
            check("bp_out_data", out_data, C3_CT);
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_out_valid", 128'(out_valid), 128'(1));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        h = cyc;
        @(posedge clk); #1;
        out_ready = 1'b0;
        wait_accept(a2);
        check("bp_accept_after_pulse", 128'(a2 - h), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        wait_out(n0 + 2);

        // back-to-back with in_valid held: accepts 16 cycles apart
        n0 = out_cnt;
        exp_q.push_back(C3_CT); exp_q.push_back(vt[1].ct); n_exp += 2;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = C3_PT;
        wait_accept(a1);
        @(posedge clk); #1;
        in_data = vt[1].pt;
        wait_accept(a2);
        check("b2b_gap", 128'(a2 - a1), 128'(16));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(n0 + 2);

        // key store not ready: no accept, no state change, then same-cycle accept
        @(posedge clk); #1;
        key_loaded = 1'b0; in_valid = 1'b1; in_data = vt[2].pt;
        @(negedge clk);
        od = out_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("nokey_in_ready", 128'(in_ready), 128'(0));
            check("nokey_busy", 128'(busy), 128'(0));
            check("nokey_out_data", out_data, od);
        end
        exp_q.push_back(vt[2].ct); n_exp++;
        n0 = out_cnt;
        @(posedge clk); #1;
        key_loaded = 1'b1;
        @(negedge clk);
        check("key_up_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(n0 + 1);
        check("key_up_latency", 128'(lat_last), 128'(15));

        // reset at round 7 discards the block
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = vt[1].pt;
        wait_accept(a1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && round != 4'd7; i++) @(negedge clk);
        check("mid_round_reached", 128'(round), 128'(7));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_state", 128'(state_dbg), 128'(IDLE));
        check("mid_rst_round", 128'(round), 128'(0));
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        n0 = out_cnt;
        repeat (30) @(negedge clk);
        check("mid_rst_no_output", 128'(out_cnt), 128'(n0));
        run_block(C3_PT, C3_CT, "after_rst");

        repeat (3) @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        check("output_count", 128'(out_cnt), 128'(n_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes256_round_sched.md
Name: aes256_round_sched

Overview:
Sequencer for the combinational AES-256 round datapath. It accepts one 128-bit block over a valid/ready handshake and applies the initial AddRoundKey. It then drives the shared round datapath for NR rounds, one round per clock, fetching each round key from an external key-schedule store by index. It returns the ciphertext over a valid/ready handshake and sits between the CTR counter/keystream logic and the round datapath.

Parameters:
DATA_WIDTH, 128, block and round-key width
NR, 14, number of cipher rounds (AES-256)
KIDX_W, 4, width of the round-key index (must hold 0..NR)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
key_loaded  in  1  key schedule store holds valid round keys 0..NR
in_valid  in  1  input block valid
in_ready  out  1  block accepted when in_valid && in_ready
in_data  in  DATA_WIDTH  plaintext / counter block
key_idx  out  KIDX_W  round-key index to the store
key_data  in  DATA_WIDTH  round key for key_idx, combinational same-cycle read
dp_state  out  DATA_WIDTH  state fed to the round datapath
dp_key  out  DATA_WIDTH  round key fed to the round datapath (= key_data)
dp_last  out  1  final round: datapath omits MixColumns
dp_result  in  DATA_WIDTH  combinational datapath result
out_valid  out  1  ciphertext valid
out_ready  in  1  downstream accepts
out_data  out  DATA_WIDTH  ciphertext (= state register)
busy  out  1  high in any state except IDLE
round  out  KIDX_W  current round counter, debug

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values (rst_n low at an edge): FSM=IDLE, round=0, state register=0, in_ready=0 during reset, out_valid=0, busy=0, dp_last=0, key_idx=0. Reset wins over every other event, including mid-round and during DONE; any in-flight block is discarded with no output.
- FSM states: IDLE, ROUND, DONE. Encode in a package enum.
- IDLE:
  - key_idx=0; in_ready = key_loaded.
  - On in_valid && in_ready: state <= in_data ^ key_data (round-0 AddRoundKey), round <= 1, go to ROUND.
  - in_data is sampled only at the handshake edge.
- ROUND:
  - key_idx=round; dp_state=state; dp_key=key_data; dp_last=(round==NR).
  - Each edge: state <= dp_result.
  - If round==NR go to DONE and hold round at NR; else round <= round+1.
  - in_ready=0. Exactly NR cycles are spent in ROUND.
- DONE:
  - out_valid=1 and out_data=state, both held stable until out_ready.
  - On out_valid && out_ready: out_valid drops next cycle, round <= 0, go to IDLE.
- Latency: input handshake at edge T produces out_valid high from cycle T+NR+1 (T+15).
- Throughput: no overlap. The next accept is at T+NR+2 at the earliest when out_ready is held high, giving 16 cycles per block.
- key_loaded low:
  - In IDLE, no accept.
  - Going low mid-ROUND is a protocol violation: the block continues and the result is undefined. The bench flags it with an assertion, not RTL.
- out_ready high while not in DONE is ignored. in_valid in ROUND/DONE is ignored; in_ready=0 there, so no data is lost.
- Outside ROUND: dp_last=0; dp_state holds state, so there is no toggling on the datapath.
- Counter arithmetic: unsigned KIDX_W bits, never wraps. Elaboration-time check: NR < 2**KIDX_W.
- Assertions:
  - out_data stable while out_valid && !out_ready.
  - in_ready and out_valid never both high.
  - round is in 0..NR.

Decomposition:
- Package aes_ctrl_pkg: sched_state_e {IDLE, ROUND, DONE}, AES_NR=14, AES_BLK_W=128, block_t typedef.
- No sub-module. The FSM and counter are inline, and the round datapath is instantiated alongside by the parent, connected through the dp_* ports.
- The bench instantiates the real round datapath plus a last-round variant selected by dp_last, and a key-schedule array model.

Test Plan:
- FIPS-197 C.3 vector: key 000102…1e1f expanded into the store, in_data=00112233445566778899aabbccddeeff, out_ready=1 -> out_valid at T+15, out_data=8ea2b7ca516745bfeafc49904b496089, key_idx steps 0,1..14.
- Backpressure: same vector, out_ready=0 for 20 cycles after out_valid -> out_data held constant, in_ready=0 throughout, accept only after out_ready pulse.
- Back-to-back: two blocks (C.3 plaintext, then all-zero plaintext) with in_valid held and out_ready=1 -> accepts exactly 16 cycles apart; second output matches model ciphertext of 000…0.
- key_loaded=0 with in_valid=1 for 10 cycles -> in_ready=0, busy=0, no state change; raise key_loaded -> accepted same cycle.
- Reset mid-op: rst_n low at round 7 for one edge -> next cycle FSM IDLE, round=0, out_valid=0, no output ever appears for that block; a following block encrypts correctly.
- dp_last check: monitor -> dp_last high only in the single cycle with key_idx=14, never in IDLE or DONE.
